avg_rr_sched: RTL and testbench
===============================

AVG_RR_SCHED -- requirements
Module: avg_rr_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one avg_n_per_clk instance.
REQ-002 SHALL have parameter NUM_INPUTS, default 16, samples per request vector.
REQ-003 SHALL have parameter DWIDTH, default 16, sample and average width.
REQ-004 SHALL have parameter TAG_DEPTH, default 8, power of 2, max outstanding averager operations.
REQ-005 SHALL have clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have req_dat_vector  in  NUM_REQ*NUM_INPUTS*DWIDTH  requester r vector at slice [r*NUM_INPUTS*DWIDTH +: NUM_INPUTS*DWIDTH].
REQ-008 SHALL have req_valid  in  NUM_REQ  per-requester request valid.
REQ-009 SHALL have req_ready  out  NUM_REQ  per-requester accept, one-hot or zero, combinational.
REQ-010 SHALL have req_mask  in  NUM_REQ  1 = requester enabled for arbitration.
REQ-011 SHALL have avg_dat_vector  out  NUM_INPUTS*DWIDTH  registered vector to averager i_dat_vector.
REQ-012 SHALL have avg_dat_valid  out  1  registered strobe to averager i_dat_valid.
REQ-013 SHALL have avg_in  in  DWIDTH  averager o_avg.
REQ-014 SHALL have avg_in_valid  in  1  averager o_avg_valid.
REQ-015 SHALL have rsp_avg  out  DWIDTH  registered average returned to owner.
REQ-016 SHALL have rsp_valid  out  NUM_REQ  one-hot one-cycle pulse identifying owner.
REQ-017 SHALL have outstanding  out  $clog2(TAG_DEPTH)+1  issued-but-unreturned count.
REQ-018 SHALL have err_underflow  out  1  sticky: result arrived with no outstanding tag.

Function
REQ-019 Eligible set SHALL be req_valid & req_mask; issue allowed only when outstanding < TAG_DEPTH.
REQ-020 Grant SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ; first eligible wins; last_grant updates only on a grant.
REQ-021 req_ready[g] SHALL assert for granted g in same cycle; handshake = req_valid[g] & req_ready[g].
REQ-022 On handshake at edge t, avg_dat_vector SHALL load requester g slice and avg_dat_valid SHALL be 1 for exactly cycle t+1; otherwise avg_dat_valid = 0 and avg_dat_vector holds.
REQ-023 On handshake, tag g SHALL push into tag FIFO (in issue order).
REQ-024 On avg_in_valid with FIFO non-empty, head tag SHALL pop; rsp_avg <= avg_in and rsp_valid <= one-hot(tag) next cycle (1-cycle latency); otherwise rsp_valid = 0, rsp_avg holds.
REQ-025 Simultaneous push and pop SHALL both occur; outstanding unchanged.
REQ-026 At outstanding == TAG_DEPTH, req_ready SHALL be 0 even if avg_in_valid same cycle (no bypass).
REQ-027 avg_in_valid with FIFO empty SHALL set err_underflow, produce no rsp_valid, leave counters unchanged.
REQ-028 Results SHALL be returned strictly in issue order; no backpressure on responses.
REQ-029 Deasserting req_mask bit SHALL only block new grants; outstanding results for that requester still return.

Reset
REQ-030 On rst: req_ready, avg_dat_valid, rsp_valid, outstanding, err_underflow = 0; avg_dat_vector, rsp_avg = 0; FIFO emptied; last_grant = NUM_REQ-1 (requester 0 first).
REQ-031 rst mid-operation SHALL discard all tags; system resets averager concurrently, else late results set err_underflow.
REQ-032 rst SHALL override simultaneous request and result inputs.

Structure
REQ-033 Shared package SHALL hold tag width function ($clog2(NUM_REQ), min 1) and default parameter constants.
REQ-034 Tag storage SHALL be sub-module avg_tag_fifo (sync FIFO, push/pop/full/empty/count, same clk/rst).
REQ-035 avg_n_per_clk SHALL be instantiated by the parent, not inside avg_rr_sched.

Verification (NUM_REQ=4, TAG_DEPTH=4, DWIDTH=16, NUM_INPUTS=16, averager latency model 3 cycles)
REQ-036 All 4 req_valid held 1 for 8 cycles -> grants 0,1,2,3,0,... with stalls at 4 outstanding; each rsp_valid returns to correct owner with correct floor average.
REQ-037 Requester 2 only, all samples 0x0010 -> avg_dat_valid one cycle after grant, rsp_avg = 0x0010, rsp_valid = 4'b0100 at averager latency+1.
REQ-038 Fill 4 outstanding, hold requests -> req_ready = 0 while full; result pop and next issue in same cycle keep outstanding = 4 thereafter.
REQ-039 avg_in_valid pulse with outstanding = 0 -> err_underflow = 1 until rst, rsp_valid stays 0.
REQ-040 req_mask = 4'b1010, all valid -> grants alternate 1,3 only; rst asserted with 2 outstanding -> all outputs 0 next cycle, next grant requester 1 (first enabled from 0).

Source files
------------

// File: rtl/avg_rr_sched_pkg.sv
// avg_rr_sched_pkg: shared defaults and tag-width helper for the averager scheduler
package avg_rr_sched_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_NUM_INPUTS = 16;
  localparam int DEF_DWIDTH = 16;
  localparam int DEF_TAG_DEPTH = 8;
  function automatic int tag_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/avg_rr_sched_tag_fifo.sv
// avg_tag_fifo: synchronous tag FIFO recording requester ids in issue order
module avg_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/avg_rr_sched.sv
// avg_rr_sched: round-robin sharing of one averager with in-order tagged result return
module avg_rr_sched
  import avg_rr_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int NUM_INPUTS = DEF_NUM_INPUTS,
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int TAG_DEPTH = DEF_TAG_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ*NUM_INPUTS*DWIDTH-1:0] req_dat_vector,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0]                  req_mask,
  output logic [NUM_INPUTS*DWIDTH-1:0]        avg_dat_vector,
  output logic                                avg_dat_valid,
  input  logic [DWIDTH-1:0]                   avg_in,
  input  logic                                avg_in_valid,
  output logic [DWIDTH-1:0]                   rsp_avg,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [$clog2(TAG_DEPTH):0]          outstanding,
  output logic                                err_underflow
);
  localparam int TW = tag_w(NUM_REQ);
  localparam int VW = NUM_INPUTS * DWIDTH;
  logic [NUM_REQ-1:0] elig, hi_mask, hi, pick;
  logic [TW-1:0] last_grant, gidx, head;
  logic full, empty, hs, pop;
  assign elig = req_valid & req_mask;
  // requesters strictly above last_grant win first; otherwise wrap to the lowest
  assign hi_mask = ~((NUM_REQ'(2) << last_grant) - NUM_REQ'(1));
  assign hi = elig & hi_mask;
  assign pick = |hi ? hi & (~hi + 1'b1) : elig & (~elig + 1'b1);
  assign req_ready = (rst || full) ? '0 : pick;
  assign hs = |(req_valid & req_ready);
  assign pop = avg_in_valid & ~empty & ~rst;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) gidx = TW'(i);
  end
  avg_tag_fifo #(.DEPTH(TAG_DEPTH), .W(TW)) u_fifo (
    .clk(clk), .rst(rst), .push(hs), .pop(pop), .din(gidx), .dout(head),
    .full(full), .empty(empty), .count(outstanding)
  );
  always_ff @(posedge clk)
    if (rst) begin
      last_grant <= TW'(NUM_REQ - 1);
      avg_dat_vector <= '0;
      avg_dat_valid <= 1'b0;
      rsp_avg <= '0;
      rsp_valid <= '0;
      err_underflow <= 1'b0;
    end else begin
      avg_dat_valid <= hs;
      if (hs) begin
        avg_dat_vector <= req_dat_vector[int'(gidx)*VW +: VW];
        last_grant <= gidx;
      end
      rsp_valid <= pop ? NUM_REQ'(1) << head : '0;
      if (pop) rsp_avg <= avg_in;
      if (avg_in_valid && empty) err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_avg_rr_sched.sv
// tb_avg_rr_sched: table, directed and random checks of avg_rr_sched against a queue model
module tb_avg_rr_sched;
  localparam int NR = 4, NI = 16, DW = 16, TD = 4, VW = NI * DW;
  typedef struct { logic [NR-1:0] valid, mask, ready; int outst; } vec_t;
  logic clk = 1'b0, rst;
  logic [NR*VW-1:0] req_dat_vector;
  logic [NR-1:0] req_valid, req_ready, req_mask, rsp_valid;
  logic [VW-1:0] avg_dat_vector;
  logic avg_dat_valid, avg_in_valid, err_underflow;
  logic [DW-1:0] avg_in, rsp_avg;
  logic [2:0] outstanding;
  int n_checks = 0, n_errors = 0, lg;
  int q_tag[$];
  logic [DW-1:0] q_avg[$];
  logic [NR-1:0] exp_rv;
  logic [DW-1:0] exp_ravg;
  logic exp_dv, exp_err, avg_en;
  logic [VW-1:0] exp_dvec;
  logic [DW-1:0] pipe_d[3];
  logic pipe_v[3];
  vec_t tbl[6];
  always #5 clk = ~clk;
  avg_rr_sched #(.NUM_REQ(NR), .NUM_INPUTS(NI), .DWIDTH(DW), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst), .req_dat_vector(req_dat_vector), .req_valid(req_valid),
    .req_ready(req_ready), .req_mask(req_mask), .avg_dat_vector(avg_dat_vector),
    .avg_dat_valid(avg_dat_valid), .avg_in(avg_in), .avg_in_valid(avg_in_valid),
    .rsp_avg(rsp_avg), .rsp_valid(rsp_valid), .outstanding(outstanding),
    .err_underflow(err_underflow)
  );
  function automatic logic [DW-1:0] avg_of(input logic [VW-1:0] v);
    int s = 0;
    for (int i = 0; i < NI; i++) s += int'(v[i*DW +: DW]);
    return DW'(s / NI);
  endfunction
  function automatic int rr_pick(input logic [NR-1:0] e, input int last);
    for (int k = 1; k <= NR; k++)
      if (e[(last + k) % NR]) return (last + k) % NR;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic randomize_data();
    for (int i = 0; i < NR * VW / 32; i++) req_dat_vector[i*32 +: 32] = $urandom;
  endtask
  // called at a falling edge with inputs stable; checks, advances the model, then the averager
  task automatic step();
    int g;
    logic [NR-1:0] er;
    logic nv, was_rst;
    logic [DW-1:0] nd;
    g = (!rst && q_tag.size() < TD) ? rr_pick(req_valid & req_mask, lg) : -1;
    er = g >= 0 ? NR'(1) << g : '0;
    chk("req_ready", req_ready, er);
    chk("outstanding", outstanding, q_tag.size());
    chk("avg_dat_valid", avg_dat_valid, exp_dv);
    chk("avg_dat_vector", avg_dat_vector, exp_dvec);
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_avg", rsp_avg, exp_ravg);
    chk("err_underflow", err_underflow, exp_err);
    nv = avg_dat_valid;
    nd = avg_of(avg_dat_vector);
    was_rst = rst;
    if (rst) begin
      q_tag.delete(); q_avg.delete(); lg = NR - 1;
      exp_dv = 0; exp_dvec = '0; exp_rv = '0; exp_ravg = '0; exp_err = 0;
    end else begin
      exp_rv = '0;
      if (avg_in_valid) begin
        if (q_tag.size() > 0) begin
          exp_rv = NR'(1) << q_tag.pop_front();
          exp_ravg = q_avg.pop_front();
        end else exp_err = 1;
      end
      exp_dv = g >= 0;
      if (g >= 0) begin
        exp_dvec = req_dat_vector[g*VW +: VW];
        q_tag.push_back(g);
        q_avg.push_back(avg_of(exp_dvec));
        lg = g;
      end
    end
    @(posedge clk); #1;
    pipe_v[2] = was_rst ? 1'b0 : pipe_v[1]; pipe_d[2] = pipe_d[1];
    pipe_v[1] = was_rst ? 1'b0 : pipe_v[0]; pipe_d[1] = pipe_d[0];
    pipe_v[0] = was_rst ? 1'b0 : nv; pipe_d[0] = nd;
    avg_in_valid = avg_en & pipe_v[2];
    avg_in = pipe_d[2];
  endtask
  initial begin
    int seen;
    logic [DW-1:0] seen_avg;
    tbl[0] = '{4'b0001, 4'b1111, 4'b0001, 0};
    tbl[1] = '{4'b0011, 4'b1111, 4'b0010, 1};
    tbl[2] = '{4'b1111, 4'b1010, 4'b1000, 2};
    tbl[3] = '{4'b0101, 4'b1111, 4'b0001, 3};
    tbl[4] = '{4'b1111, 4'b1111, 4'b0000, 4};
    tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 4};
    rst = 1; req_valid = '0; req_mask = '1; req_dat_vector = '0;
    avg_in = '0; avg_in_valid = 0; avg_en = 0;
    for (int i = 0; i < 3; i++) begin pipe_v[i] = 0; pipe_d[i] = '0; end
    lg = NR - 1; exp_dv = 0; exp_dvec = '0; exp_rv = '0; exp_ravg = '0; exp_err = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk); step();
    rst = 0;
    foreach (tbl[i]) begin
      req_valid = tbl[i].valid; req_mask = tbl[i].mask; randomize_data();
      @(negedge clk);
      chk("tbl_ready", req_ready, tbl[i].ready);
      chk("tbl_outstanding", outstanding, tbl[i].outst);
      step();
    end
    rst = 1; req_valid = '0; @(negedge clk); step();
    rst = 0; avg_en = 1; req_mask = '1;
    // single requester, constant samples: fixed latency and exact average
    for (int i = 0; i < NI; i++) req_dat_vector[2*VW + i*DW +: DW] = 16'h0010;
    req_valid = 4'b0100; @(negedge clk); step();
    req_valid = '0; seen = 0; seen_avg = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid != '0 && seen == 0) begin
        seen = k; seen_avg = rsp_avg;
        chk("req2_owner", rsp_valid, 4'b0100);
      end
      step();
    end
    chk("req2_latency", seen, 5);
    chk("req2_avg", seen_avg, 16'h0010);
    // result with nothing outstanding
    avg_in_valid = 1; avg_in = 16'h1234;
    @(negedge clk); step();
    for (int k = 0; k < 3; k++) begin @(negedge clk); step(); end
    @(negedge clk);
    chk("underflow_sticky", err_underflow, 1'b1);
    chk("underflow_no_rsp", rsp_valid, 4'b0000);
    rst = 1; step();
    rst = 0;
    // masked arbitration, then reset with two outstanding
    req_mask = 4'b1010; req_valid = '1; randomize_data();
    @(negedge clk); chk("mask_g1", req_ready, 4'b0010); step();
    @(negedge clk); chk("mask_g2", req_ready, 4'b1000); step();
    rst = 1; @(negedge clk); chk("mask_outst", outstanding, 3'd2); step();
    rst = 0;
    @(negedge clk);
    chk("rst_rsp_clear", rsp_valid, 4'b0000);
    chk("rst_dv_clear", avg_dat_valid, 1'b0);
    chk("mask_after_rst", req_ready, 4'b0010);
    step();
    // all requesters saturating the tag queue
    req_mask = '1; req_valid = '1;
    for (int k = 0; k < 30; k++) begin randomize_data(); @(negedge clk); step(); end
    for (int k = 0; k < 1500; k++) begin
      req_valid = NR'($urandom);
      req_mask = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '1;
      rst = $urandom_range(0, 199) == 0;
      randomize_data();
      @(negedge clk); step();
    end
    rst = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
